// File: rtl/mcpu_mem_responder.sv
// Memory-side responder for the 8-bit minimal CPU: 2**AW x DW RAM with a byte-stream program loader.
// Optional stored-parity checking is enabled by defining MEM_PARITY_EN.
module mcpu_mem_responder #(
  parameter int unsigned AW       = 6,
  parameter int unsigned DW       = 8,
  parameter int unsigned LOAD_LEN = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_dout,
  output logic [DW-1:0] cpu_din,
  input  logic          cpu_oe_n,
  input  logic          cpu_we_n,
  output logic          cpu_rst_n,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          ld_busy,
  output logic          ld_done,
  input  logic          par_inj,
  output logic          par_err
);

  localparam int unsigned   DEPTH = 2 ** AW;
  localparam logic [AW-1:0] LAST  = AW'(LOAD_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          cpu_rst_n_q, cpu_rst_n_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  logic          wr_tog_q, wr_tog_d;
  logic          wr_ack_q, wr_ack_d;
  logic [AW-1:0] wr_adr_q, wr_adr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  logic          wr_pend;
  logic          ld_fire;
  logic          fwd_hit;

  // A store is pending while the negedge toggle and posedge acknowledge differ;
  // this lets the two clock edges share wr_pend without a multiply-driven flop.
  assign wr_pend = wr_tog_q ^ wr_ack_q;
  assign fwd_hit = wr_pend && (cpu_adr == wr_adr_q);
  assign cpu_din = fwd_hit ? wr_data_q : mem_q[cpu_adr];

  assign ld_ready  = (state_q == ST_LOAD);
  assign ld_busy   = (state_q != ST_IDLE);
  assign ld_done   = (state_q == ST_DONE);
  assign ld_fire   = ld_ready && ld_valid;
  assign cpu_rst_n = cpu_rst_n_q;

  always_comb begin
    wr_tog_d  = wr_tog_q;
    wr_adr_d  = wr_adr_q;
    wr_data_d = wr_data_q;
    if (state_q == ST_IDLE && !cpu_we_n) begin
      wr_tog_d  = ~wr_tog_q;
      wr_adr_d  = cpu_adr;
      wr_data_d = cpu_dout;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      wr_tog_q  <= 1'b0;
      wr_adr_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_tog_q  <= wr_tog_d;
      wr_adr_q  <= wr_adr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ld_start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (ld_valid) begin
          if (cnt_q == LAST) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    cpu_rst_n_d = (state_d == ST_IDLE);
    wr_ack_d    = wr_tog_q;
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_pend) begin
      mem_d[wr_adr_q] = wr_data_q;
    end
    if (ld_fire) begin
      mem_d[cnt_q] = ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cpu_rst_n_q <= 1'b0;
      wr_ack_q    <= 1'b0;
      mem_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      wr_ack_q    <= wr_ack_d;
      mem_q       <= mem_d;
    end
  end

`ifdef MEM_PARITY_EN
  logic [DEPTH-1:0] par_q, par_d;
  logic             par_err_q, par_err_d;
  logic             unused_oe;

  assign unused_oe = cpu_oe_n;
  assign par_err   = par_err_q;

  always_comb begin
    par_d = par_q;
    if (wr_pend) begin
      par_d[wr_adr_q] = (^wr_data_q) ^ par_inj;
    end
    if (ld_fire) begin
      par_d[cnt_q] = (^ld_data) ^ par_inj;
    end
    par_err_d = par_err_q;
    // Forwarded store data has not reached the array yet, so it is treated as good.
    if (cpu_rst_n_q && !fwd_hit && ((^mem_q[cpu_adr]) != par_q[cpu_adr])) begin
      par_err_d = 1'b1;
    end
    if (state_q == ST_IDLE && state_d == ST_LOAD) begin
      par_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q     <= '0;
      par_err_q <= 1'b0;
    end else begin
      par_q     <= par_d;
      par_err_q <= par_err_d;
    end
  end
`else
  logic unused_in;

  assign unused_in = cpu_oe_n ^ par_inj;
  assign par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mcpu_mem_responder.sv
// Directed bench for mcpu_mem_responder: loader bursts, backpressure, CPU store forwarding, abort, parity.
// Loaded bytes are pushed to a scoreboard queue and popped on CPU read-back.
module tb_mcpu_mem_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] cpu_adr;
  logic [7:0] cpu_dout;
  logic [7:0] cpu_din;
  logic       cpu_oe_n;
  logic       cpu_we_n;
  logic       cpu_rst_n;
  logic       ld_start;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       ld_busy;
  logic       ld_done;
  logic       par_inj;
  logic       par_err;

  int         vectors    = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];

`ifdef MEM_PARITY_EN
  localparam logic EXP_PAR = 1'b1;
`else
  localparam logic EXP_PAR = 1'b0;
`endif

  mcpu_mem_responder #(.AW(6), .DW(8), .LOAD_LEN(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_adr  (cpu_adr),
    .cpu_dout (cpu_dout),
    .cpu_din  (cpu_din),
    .cpu_oe_n (cpu_oe_n),
    .cpu_we_n (cpu_we_n),
    .cpu_rst_n(cpu_rst_n),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .ld_busy  (ld_busy),
    .ld_done  (ld_done),
    .par_inj  (par_inj),
    .par_err  (par_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic readback_all(input string tag);
    logic [7:0] e;
    for (int a = 0; a < 64; a++) begin
      cpu_adr = 6'(a);
      #1;
      if (exp_q.size() == 0) begin
        chk({tag, "_sb_empty"}, 8'h01, 8'h00);
      end else begin
        e = exp_q.pop_front();
        chk(tag, cpu_din, e);
      end
    end
  endtask

  initial begin
    int beats;
    int done_cnt;

    rst      = 1'b0;
    cpu_adr  = '0;
    cpu_dout = '0;
    cpu_oe_n = 1'b1;
    cpu_we_n = 1'b1;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_data  = '0;
    par_inj  = 1'b0;

    // reset state
    #2;
    chk("rst_cpu_rst_n", {7'd0, cpu_rst_n}, 8'h00);
    chk("rst_ld_ready", {7'd0, ld_ready}, 8'h00);
    chk("rst_ld_busy", {7'd0, ld_busy}, 8'h00);
    chk("rst_ld_done", {7'd0, ld_done}, 8'h00);
    chk("rst_par_err", {7'd0, par_err}, 8'h00);
    for (int a = 0; a < 64; a += 9) begin
      cpu_adr = 6'(a);
      #1;
      chk("rst_din", cpu_din, 8'h00);
    end
    tick();
    chk("rst_hold_cpu_rst_n", {7'd0, cpu_rst_n}, 8'h00);
    rst = 1'b1;
    tick();
    chk("rel_cpu_rst_n", {7'd0, cpu_rst_n}, 8'h01);

    // back-to-back load burst
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk("ld_ready_in_load", {7'd0, ld_ready}, 8'h01);
    chk("ld_busy_in_load", {7'd0, ld_busy}, 8'h01);
    chk("cpu_held_in_load", {7'd0, cpu_rst_n}, 8'h00);
    for (int i = 0; i < 64; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'(i) ^ 8'hA5;
      exp_q.push_back(8'(i) ^ 8'hA5);
      tick();
      if (i < 63) chk("no_early_done", {7'd0, ld_done}, 8'h00);
    end
    ld_valid = 1'b0;
    chk("ld_done_pulse", {7'd0, ld_done}, 8'h01);
    chk("ready_low_done", {7'd0, ld_ready}, 8'h00);
    chk("cpu_held_in_done", {7'd0, cpu_rst_n}, 8'h00);
    tick();
    chk("ld_done_one_cycle", {7'd0, ld_done}, 8'h00);
    chk("cpu_released", {7'd0, cpu_rst_n}, 8'h01);
    chk("busy_after_load", {7'd0, ld_busy}, 8'h00);
    cpu_adr = 6'd3;
    #1;
    chk("adr3_after_load", cpu_din, 8'hA6);
    readback_all("load_rd");

    // backpressured burst; ld_valid on the start cycle must be ignored
    tick();
    ld_start = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 8'hFF;
    tick();
    ld_start = 1'b0;
    beats    = 0;
    done_cnt = 0;
    for (int cyc = 0; cyc < 400 && beats < 64; cyc++) begin
      if (cyc % 3 == 0) begin
        ld_valid = 1'b1;
        ld_data  = 8'(beats) ^ 8'h3C;
        exp_q.push_back(8'(beats) ^ 8'h3C);
        beats++;
      end else begin
        ld_valid = 1'b0;
        ld_data  = 8'hEE;
      end
      tick();
      done_cnt += int'(ld_done);
    end
    ld_valid = 1'b0;
    tick();
    done_cnt += int'(ld_done);
    chk("bp_beats", 8'(beats), 8'd64);
    chk("bp_done_count", 8'(done_cnt), 8'd1);
    chk("bp_released", {7'd0, cpu_rst_n}, 8'h01);
    readback_all("bp_rd");

    // CPU store with forwarding
    tick();
    cpu_adr  = 6'h3F;
    cpu_dout = 8'h5A;
    cpu_we_n = 1'b0;
    #1;
    chk("st_before_neg", cpu_din, 8'h3F ^ 8'h3C);
    @(negedge clk);
    #1;
    chk("st_forward", cpu_din, 8'h5A);
    cpu_we_n = 1'b0;
    cpu_we_n = 1'b1;
    cpu_adr  = 6'h3E;
    #1;
    chk("st_neighbour", cpu_din, 8'h3E ^ 8'h3C);
    cpu_adr = 6'h3F;
    tick();
    cpu_adr = 6'h00;
    #1;
    chk("st_other_adr", cpu_din, 8'h3C);
    cpu_adr = 6'h3F;
    #1;
    chk("st_committed", cpu_din, 8'h5A);

    // reset mid-load
    tick();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'h11 + 8'(i);
      tick();
    end
    ld_valid = 1'b0;
    chk("ab_busy_before", {7'd0, ld_busy}, 8'h01);
    rst = 1'b0;
    #1;
    chk("ab_busy", {7'd0, ld_busy}, 8'h00);
    chk("ab_ready", {7'd0, ld_ready}, 8'h00);
    chk("ab_cpu_rst_n", {7'd0, cpu_rst_n}, 8'h00);
    for (int a = 0; a < 10; a++) begin
      cpu_adr = 6'(a);
      #1;
      chk("ab_cleared", cpu_din, 8'h00);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("ab_no_done", {7'd0, ld_done}, 8'h00);
    end
    rst = 1'b1;
    chk("ab_still_held", {7'd0, cpu_rst_n}, 8'h00);
    tick();
    chk("ab_released", {7'd0, cpu_rst_n}, 8'h01);
    chk("ab_no_done_after", {7'd0, ld_done}, 8'h00);
    chk("ab_idle", {7'd0, ld_busy}, 8'h00);

    // parity injection on beat 5
    cpu_adr  = 6'd0;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'(i);
      par_inj  = (i == 5);
      tick();
    end
    ld_valid = 1'b0;
    par_inj  = 1'b0;
    tick();
    tick();
    chk("par_clean_adr0", {7'd0, par_err}, 8'h00);
    cpu_adr = 6'd5;
    #1;
    chk("par_data5", cpu_din, 8'h05);
    tick();
    chk("par_detect", {7'd0, par_err}, {7'd0, EXP_PAR});
    cpu_adr = 6'd0;
    tick();
    chk("par_sticky", {7'd0, par_err}, {7'd0, EXP_PAR});
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk("par_clr_on_load", {7'd0, par_err}, 8'h00);

    chk("sb_drained", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
